// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - parametrised single-clock FIFO with STANDARD/FWFT read modes
// Occupancy count, exact full/empty accept rules, registered status flags and error pulses.
module sync_fifo_prog #(
  parameter int    DATA_WIDTH        = 36,
  parameter int    DEPTH             = 1024,
  parameter string READ_MODE         = "STANDARD",
  parameter int    PROG_EMPTY_THRESH = 4,
  parameter int    PROG_FULL_THRESH  = DEPTH - 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         WR_EN,
  input  logic [DATA_WIDTH-1:0]        WR_DATA,
  input  logic                         RD_EN,
  output logic [DATA_WIDTH-1:0]        RD_DATA,
  output logic                         RD_VALID,
  output logic [$clog2(DEPTH):0]       COUNT,
  output logic                         EMPTY,
  output logic                         ALMOST_EMPTY,
  output logic                         FULL,
  output logic                         ALMOST_FULL,
  output logic                         PROG_EMPTY,
  output logic                         PROG_FULL,
  output logic                         OVERFLOW,
  output logic                         UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
    $fatal(1, "%m: DATA_WIDTH=%0d outside 1..1024", DATA_WIDTH);
  end
  if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "%m: DEPTH=%0d must be a power of two in 4..65536", DEPTH);
  end
  if (READ_MODE != "STANDARD" && READ_MODE != "FWFT") begin : g_bad_mode
    $fatal(1, "%m: READ_MODE=%s is not STANDARD or FWFT", READ_MODE);
  end
  if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pe
    $fatal(1, "%m: PROG_EMPTY_THRESH=%0d outside 1..DEPTH-1", PROG_EMPTY_THRESH);
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH - 1) begin : g_bad_pf
    $fatal(1, "%m: PROG_FULL_THRESH=%0d outside 1..DEPTH-1", PROG_FULL_THRESH);
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, aempty_q, full_q, afull_q, pempty_q, pfull_q;
  logic                  ovf_q, unf_q;
  logic                  rd_ok, wr_ok;

  // A write at full is allowed only because the coincident read frees a slot.
  assign rd_ok = RD_EN & (count_q != '0);
  assign wr_ok = WR_EN & ((count_q != CW'(DEPTH)) | rd_ok);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET_N && wr_ok) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      pempty_q <= 1'b1;
      pfull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      aempty_q <= (count_d == CW'(1));
      full_q   <= (count_d == CW'(DEPTH));
      afull_q  <= (count_d == CW'(DEPTH - 1));
      pempty_q <= (count_d <= CW'(PROG_EMPTY_THRESH));
      pfull_q  <= (count_d >= CW'(PROG_FULL_THRESH));
      ovf_q    <= WR_EN & ~wr_ok;
      unf_q    <= RD_EN & ~rd_ok;
    end
  end

  if (READ_MODE == "FWFT") begin : g_fwft
    // Head word is shown as soon as it is stored; zeros while empty.
    assign RD_DATA  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign RD_VALID = ~empty_q;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) rd_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
  end

  assign COUNT        = count_q;
  assign EMPTY        = empty_q;
  assign ALMOST_EMPTY = aempty_q;
  assign FULL         = full_q;
  assign ALMOST_FULL  = afull_q;
  assign PROG_EMPTY   = pempty_q;
  assign PROG_FULL    = pfull_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed bench for sync_fifo_prog in STANDARD and FWFT modes
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        s_wr, s_rd, f_wr, f_rd;
  logic [15:0] s_wd, f_wd;
  logic [15:0] s_rdata, f_rdata;
  logic        s_rv, f_rv;
  logic [3:0]  s_cnt, f_cnt;
  logic        s_e, s_ae, s_f, s_af, s_pe, s_pf, s_ovf, s_unf;
  logic        f_e, f_ae, f_f, f_af, f_pe, f_pf, f_ovf, f_unf;

  sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(8), .READ_MODE("STANDARD"),
                   .PROG_EMPTY_THRESH(2), .PROG_FULL_THRESH(6)) u_std (
    .CLK(clk), .RESET_N(resetn), .WR_EN(s_wr), .WR_DATA(s_wd), .RD_EN(s_rd),
    .RD_DATA(s_rdata), .RD_VALID(s_rv), .COUNT(s_cnt), .EMPTY(s_e),
    .ALMOST_EMPTY(s_ae), .FULL(s_f), .ALMOST_FULL(s_af), .PROG_EMPTY(s_pe),
    .PROG_FULL(s_pf), .OVERFLOW(s_ovf), .UNDERFLOW(s_unf));

  sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(8), .READ_MODE("FWFT")) u_fwft (
    .CLK(clk), .RESET_N(resetn), .WR_EN(f_wr), .WR_DATA(f_wd), .RD_EN(f_rd),
    .RD_DATA(f_rdata), .RD_VALID(f_rv), .COUNT(f_cnt), .EMPTY(f_e),
    .ALMOST_EMPTY(f_ae), .FULL(f_f), .ALMOST_FULL(f_af), .PROG_EMPTY(f_pe),
    .PROG_FULL(f_pf), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf));

  int checks = 0;
  int failures = 0;

  // flag order: {EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, PROG_EMPTY, PROG_FULL, OVERFLOW, UNDERFLOW}
  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] wd;
    logic [3:0]  cnt;
    logic [7:0]  flg;
    logic        rv;
    logic [15:0] rdat;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] s_flags();
    return {s_e, s_ae, s_f, s_af, s_pe, s_pf, s_ovf, s_unf};
  endfunction

  function automatic logic [7:0] f_flags();
    return {f_e, f_ae, f_f, f_af, f_pe, f_pf, f_ovf, f_unf};
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'h0001, 4'd1, 8'b01001000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0002, 4'd2, 8'b00001000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 16'h0003, 4'd3, 8'b00000000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 16'h0004, 4'd4, 8'b00000000, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'h0005, 4'd5, 8'b00000000, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 16'h0006, 4'd6, 8'b00000100, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 16'h0007, 4'd7, 8'b00010100, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h0008, 4'd8, 8'b00100100, 1'b0, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 16'hBEEF, 4'd8, 8'b00100110, 1'b0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 16'hCAFE, 4'd8, 8'b00100100, 1'b1, 16'h0001};
    tbl[10] = '{1'b0, 1'b1, 16'h0000, 4'd7, 8'b00010100, 1'b1, 16'h0002};
    tbl[11] = '{1'b0, 1'b1, 16'h0000, 4'd6, 8'b00000100, 1'b1, 16'h0003};
    tbl[12] = '{1'b0, 1'b1, 16'h0000, 4'd5, 8'b00000000, 1'b1, 16'h0004};
    tbl[13] = '{1'b0, 1'b1, 16'h0000, 4'd4, 8'b00000000, 1'b1, 16'h0005};
    tbl[14] = '{1'b0, 1'b1, 16'h0000, 4'd3, 8'b00000000, 1'b1, 16'h0006};
    tbl[15] = '{1'b0, 1'b1, 16'h0000, 4'd2, 8'b00001000, 1'b1, 16'h0007};
    tbl[16] = '{1'b0, 1'b1, 16'h0000, 4'd1, 8'b01001000, 1'b1, 16'h0008};
    tbl[17] = '{1'b0, 1'b1, 16'h0000, 4'd0, 8'b10001000, 1'b1, 16'hCAFE};
    tbl[18] = '{1'b0, 1'b1, 16'h0000, 4'd0, 8'b10001001, 1'b0, 16'hCAFE};
    tbl[19] = '{1'b1, 1'b1, 16'h1234, 4'd1, 8'b01001001, 1'b0, 16'hCAFE};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 4'd1, 8'b01001000, 1'b0, 16'hCAFE};
    tbl[21] = '{1'b0, 1'b1, 16'h0000, 4'd0, 8'b10001000, 1'b1, 16'h1234};

    resetn = 1'b0;
    s_wr = 1'b0; s_rd = 1'b0; s_wd = '0;
    f_wr = 1'b0; f_rd = 1'b0; f_wd = '0;
    tick();
    tick();
    check("reset_std_count", 32'(s_cnt), 32'd0);
    check("reset_std_flags", 32'(s_flags()), 32'h88);
    check("reset_std_rv", 32'(s_rv), 32'd0);
    check("reset_std_rdata", 32'(s_rdata), 32'd0);
    check("reset_fwft_flags", 32'(f_flags()), 32'h88);
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      s_wr = tbl[i].wr; s_rd = tbl[i].rd; s_wd = tbl[i].wd;
      tick();
      check($sformatf("row%0d_count", i), 32'(s_cnt), 32'(tbl[i].cnt));
      check($sformatf("row%0d_flags", i), 32'(s_flags()), 32'(tbl[i].flg));
      check($sformatf("row%0d_rvalid", i), 32'(s_rv), 32'(tbl[i].rv));
      check($sformatf("row%0d_rdata", i), 32'(s_rdata), 32'(tbl[i].rdat));
    end

    // Pointers start at 2 here; 20 write/read pairs wrap them more than twice.
    for (int i = 0; i < 20; i++) begin
      s_wr = 1'b1; s_rd = 1'b0; s_wd = 16'h5000 + 16'(i);
      tick();
      s_wr = 1'b0; s_rd = 1'b1;
      tick();
      check($sformatf("wrap%0d_rdata", i), 32'(s_rdata), 32'h5000 + 32'(i));
      check($sformatf("wrap%0d_rv_count", i), {27'd0, s_rv, s_cnt}, {27'd0, 1'b1, 4'd0});
    end
    s_rd = 1'b0;

    for (int i = 0; i < 5; i++) begin
      s_wr = 1'b1; s_wd = 16'h7000 + 16'(i);
      tick();
    end
    check("prefill_count", 32'(s_cnt), 32'd5);
    resetn = 1'b0; s_wr = 1'b1; s_rd = 1'b1; s_wd = 16'hDEAD;
    tick();
    check("midreset_count", 32'(s_cnt), 32'd0);
    check("midreset_flags", 32'(s_flags()), 32'h88);
    check("midreset_rv_rdata", {15'd0, s_rv, s_rdata}, 32'd0);
    resetn = 1'b1; s_wr = 1'b1; s_rd = 1'b0; s_wd = 16'h4242;
    tick();
    check("postreset_wr_count", 32'(s_cnt), 32'd1);
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    check("postreset_rdata", 32'(s_rdata), 32'h4242);
    check("postreset_rv_count", {27'd0, s_rv, s_cnt}, {27'd0, 1'b1, 4'd0});
    s_rd = 1'b0;

    f_wr = 1'b1; f_wd = 16'h00AA;
    tick();
    check("fwft_first_rdata", 32'(f_rdata), 32'h00AA);
    check("fwft_first_empty_rv", {30'd0, f_e, f_rv}, 32'b01);
    f_wd = 16'h00BB;
    tick();
    check("fwft_second_rdata", 32'(f_rdata), 32'h00AA);
    check("fwft_second_count", 32'(f_cnt), 32'd2);
    f_wr = 1'b0; f_rd = 1'b1;
    tick();
    check("fwft_pop1_rdata", 32'(f_rdata), 32'h00BB);
    tick();
    check("fwft_pop2_rdata", 32'(f_rdata), 32'h0000);
    check("fwft_pop2_flags", 32'(f_flags()), 32'h88);
    tick();
    check("fwft_underflow", 32'(f_flags()), 32'h89);
    f_rd = 1'b0;
    tick();
    check("fwft_underflow_clear", 32'(f_flags()), 32'h88);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
